// File: rtl/cp0_timer_ctl.sv
// cp0_timer_ctl: system-control coprocessor for the pipelined MIPS core.
//   Holds SR, Cause, EPC and PrID, plus an optional Count/Compare timer whose
//   pending flag becomes the topmost interrupt line.
//
// Parameters
//   NUM_HWINT  external interrupt lines; NUM_HWINT+TIMER_EN must be 1..6
//   TIMER_EN   1 = build Count/Compare and the timer interrupt line
//   PRID_VAL   read-only processor ID
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   hwint             level-sensitive interrupt lines from the bridge
//   wen, sel, din     mtc0 write strobe, register select, write data
//   dout              mfc0 read data (combinational on sel)
//   exl_set, exl_clr  exception entry / eret this cycle
//   exc_code, epc_in  cause code and return PC[31:2] captured on entry
//   epc_out           current EPC[31:2]
//   int_req           interrupt request to the pipeline
//   timer_irq         timer pending flag (0 without a timer)
module cp0_timer_ctl #(
   parameter int          NUM_HWINT = 5,
   parameter int          TIMER_EN  = 1,
   parameter logic [31:0] PRID_VAL  = 32'hbbaaccff
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_HWINT-1:0] hwint,
   input  logic                 wen,
   input  logic [4:0]           sel,
   input  logic [31:0]          din,
   output logic [31:0]          dout,
   input  logic                 exl_set,
   input  logic                 exl_clr,
   input  logic [4:0]           exc_code,
   input  logic [29:0]          epc_in,
   output logic [29:0]          epc_out,
   output logic                 int_req,
   output logic                 timer_irq
);

   localparam int          NLINES = NUM_HWINT + TIMER_EN;
   // Only the IM/IP bits backed by a real line exist; the rest read 0.
   localparam logic [5:0]  LMASK  = 6'((1 << NLINES) - 1);

   localparam logic [4:0] SEL_COUNT   = 5'd9;
   localparam logic [4:0] SEL_COMPARE = 5'd11;
   localparam logic [4:0] SEL_SR      = 5'd12;
   localparam logic [4:0] SEL_CAUSE   = 5'd13;
   localparam logic [4:0] SEL_EPC     = 5'd14;
   localparam logic [4:0] SEL_PRID    = 5'd15;

   logic [5:0]  im;
   logic [5:0]  ip;
   logic        ie;
   logic        exl;
   logic [4:0]  exc;
   logic [29:0] epc;
   logic [31:0] count;
   logic [31:0] compare;
   logic [5:0]  lines;
   logic [31:0] sr;
   logic [31:0] cause;

   // Line i lands on SR/Cause bit 10+i; the timer sits just above hwint.
   generate
      if (TIMER_EN != 0) begin : g_lines_t
         assign lines = 6'({timer_irq, hwint});
      end else begin : g_lines_n
         assign lines = 6'(hwint);
      end
   endgenerate

   // Live lines, not IP, so a request reaches the pipeline with no delay.
   assign int_req = (|(lines & im)) & ie & ~exl;

   assign sr      = {16'b0, im, 8'b0, exl, ie};
   assign cause   = {16'b0, ip, 3'b0, exc, 2'b0};
   assign epc_out = epc;

   always_ff @(posedge clk) begin
      if (rst) begin
         im  <= '0;
         ip  <= '0;
         ie  <= 1'b0;
         exl <= 1'b0;
         exc <= '0;
         epc <= '0;
      end else begin
         if (wen && sel == SEL_SR) begin
            im  <= din[15:10] & LMASK;
            exl <= din[1];
            ie  <= din[0];
         end
         // Priority on EXL: exception entry > eret > mtc0.
         if (exl_clr)
            exl <= 1'b0;
         if (exl_set) begin
            exl <= 1'b1;
            exc <= exc_code;
            epc <= epc_in;
         end else if (wen && sel == SEL_EPC) begin
            epc <= din[31:2];
         end
         // IP freezes while EXL is set so the handler sees the entry cause.
         if (!exl)
            ip <= lines;
      end
   end

   generate
      if (TIMER_EN != 0) begin : g_timer
         logic tirq;
         always_ff @(posedge clk) begin
            if (rst) begin
               count   <= '0;
               compare <= '1;
               tirq    <= 1'b0;
            end else begin
               count <= (wen && sel == SEL_COUNT) ? din : count + 32'd1;
               // A Compare write beats a same-cycle match.
               if (wen && sel == SEL_COMPARE) begin
                  compare <= din;
                  tirq    <= 1'b0;
               end else if (count == compare) begin
                  tirq <= 1'b1;
               end
            end
         end
         assign timer_irq = tirq;
      end else begin : g_no_timer
         assign count     = '0;
         assign compare   = '0;
         assign timer_irq = 1'b0;
      end
   endgenerate

   always_comb begin
      dout = '0;
      case (sel)
         SEL_COUNT:   dout = count;
         SEL_COMPARE: dout = compare;
         SEL_SR:      dout = sr;
         SEL_CAUSE:   dout = cause;
         SEL_EPC:     dout = {epc, 2'b00};
         SEL_PRID:    dout = PRID_VAL;
         default:     dout = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_timer_ctl.sv
// Bench for cp0_timer_ctl: directed stimulus pushes hand-computed expectations
// into a queue; a monitor on the falling edge pops and compares them.
module tb_cp0_timer_ctl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  hwint;
   logic        wen;
   logic [4:0]  sel;
   logic [31:0] din;
   logic [31:0] dout;
   logic        exl_set, exl_clr;
   logic [4:0]  exc_code;
   logic [29:0] epc_in, epc_out;
   logic        int_req, timer_irq;

   // Timer-less instance with six hardware lines.
   logic [5:0]  u1_hwint;
   logic        u1_wen;
   logic [4:0]  u1_sel;
   logic [31:0] u1_din, u1_dout;
   logic [29:0] u1_epc_out;
   logic        u1_int_req, u1_timer_irq;

   always #5 clk = ~clk;

   cp0_timer_ctl #(.NUM_HWINT(5), .TIMER_EN(1), .PRID_VAL(32'hbbaaccff)) u0 (
      .clk(clk), .rst(rst), .hwint(hwint), .wen(wen), .sel(sel), .din(din),
      .dout(dout), .exl_set(exl_set), .exl_clr(exl_clr), .exc_code(exc_code),
      .epc_in(epc_in), .epc_out(epc_out), .int_req(int_req), .timer_irq(timer_irq));

   cp0_timer_ctl #(.NUM_HWINT(6), .TIMER_EN(0), .PRID_VAL(32'hbbaaccff)) u1 (
      .clk(clk), .rst(rst), .hwint(u1_hwint), .wen(u1_wen), .sel(u1_sel), .din(u1_din),
      .dout(u1_dout), .exl_set(1'b0), .exl_clr(1'b0), .exc_code(5'd0),
      .epc_in(30'd0), .epc_out(u1_epc_out), .int_req(u1_int_req), .timer_irq(u1_timer_irq));

   typedef struct {
      string       name;
      int          sig;
      logic [31:0] exp;
   } chk_t;

   chk_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // sig: 0 dout, 1 int_req, 2 timer_irq, 3 epc_out, 4 u1 dout, 5 u1 int_req, 6 u1 timer_irq
   task automatic want(input string name, input int sig, input logic [31:0] exp);
      chk_t c;
      c.name = name; c.sig = sig; c.exp = exp;
      q.push_back(c);
   endtask

   // Inputs change just after the falling edge; the next rising edge samples
   // them and the monitor checks at the falling edge after that.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      while (q.size() > 0) begin
         chk_t c;
         logic [31:0] act;
         c = q.pop_front();
         case (c.sig)
            0:       act = dout;
            1:       act = {31'b0, int_req};
            2:       act = {31'b0, timer_irq};
            3:       act = {2'b0, epc_out};
            4:       act = u1_dout;
            5:       act = {31'b0, u1_int_req};
            default: act = {31'b0, u1_timer_irq};
         endcase
         n_chk++;
         if (act !== c.exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1; hwint = '0; wen = 0; sel = 5'd12; din = '0;
      exl_set = 0; exl_clr = 0; exc_code = '0; epc_in = '0;
      u1_hwint = '0; u1_wen = 0; u1_sel = 5'd9; u1_din = '0;
      step();

      // Reset state
      sel = 5'd9;  want("rst_count", 0, 32'h0); want("rst_int_req", 1, 0); step();
      sel = 5'd11; want("rst_compare", 0, 32'hFFFF_FFFF); want("rst_timer_irq", 2, 0); step();
      rst = 0;
      sel = 5'd12; want("rst_sr", 0, 32'h0); step();
      sel = 5'd13; want("rst_cause", 0, 32'h0); step();
      sel = 5'd14; want("rst_epc", 0, 32'h0); want("rst_epc_out", 3, 0); step();
      sel = 5'd15; want("prid", 0, 32'hbbaaccff); step();
      sel = 5'd3;  want("unmapped_sel", 0, 32'h0); step();

      // Hardware interrupt path
      wen = 1; sel = 5'd12; din = 32'h0000_8401;
      want("sr_write", 0, 32'h0000_8401); want("int_idle", 1, 0); step();
      wen = 0; hwint = 5'b00001; want("int_hw0", 1, 1); step();
      sel = 5'd13; want("cause_hw0", 0, 32'h0000_0400); step();
      hwint = 5'b00010; want("int_hw1_masked", 1, 0); want("cause_hw1", 0, 32'h0000_0800); step();

      // Exception entry freezes IP, eret releases it
      hwint = 5'b00001; want("int_hw0_again", 1, 1); step();
      exl_set = 1; epc_in = 30'h0000_1004; exc_code = 5'd0; sel = 5'd12;
      want("sr_exl", 0, 32'h0000_8403); want("int_exl_blk", 1, 0); want("epc_entry", 3, 32'h1004); step();
      exl_set = 0; hwint = '0; sel = 5'd13; want("cause_frozen", 0, 32'h0000_0400); step();
      exl_clr = 1; sel = 5'd12; want("sr_eret", 0, 32'h0000_8401); step();
      exl_clr = 0; sel = 5'd13; want("cause_follow", 0, 32'h0); step();

      // Count/Compare timer
      wen = 1; sel = 5'd9; din = 32'd10; want("count_load", 0, 32'd10); step();
      sel = 5'd11; din = 32'd20; want("cmp_write_irq", 2, 0); step();
      wen = 0; sel = 5'd9;
      for (int m = 1; m <= 9; m++) begin
         want("count_run", 0, 32'(11 + m)); want("timer_wait", 2, 0); want("int_wait", 1, 0); step();
      end
      want("timer_fire", 2, 1); want("int_timer", 1, 1); want("count_after", 0, 32'd21); step();
      want("timer_hold", 2, 1); step();
      wen = 1; sel = 5'd11; din = 32'd100; want("timer_clear", 2, 0); want("int_clear", 1, 0); step();
      wen = 0;

      // Entry beats same-cycle mtc0 EPC; records exc_code
      wen = 1; sel = 5'd14; din = 32'h80; exl_set = 1; epc_in = 30'h40; exc_code = 5'd12;
      want("epc_prio", 3, 32'h40); want("epc_dout", 0, 32'h100); step();
      wen = 0; exl_set = 0; sel = 5'd13; want("cause_exc", 0, 32'h0000_0030); step();
      exl_clr = 1; sel = 5'd12; want("sr_eret2", 0, 32'h0000_8401); step();
      exl_set = 1; exl_clr = 1; epc_in = 30'h44; exc_code = 5'd0;
      want("set_clr_prio", 0, 32'h0000_8403); want("epc_set_clr", 3, 32'h44); step();
      exl_set = 0; want("sr_eret3", 0, 32'h0000_8401); step();
      // Entry overrides mtc0 EXL but keeps the written IM/IE
      exl_clr = 0; wen = 1; din = 32'h0000_0400; exl_set = 1; epc_in = 30'h48;
      want("sr_exl_override", 0, 32'h0000_0402); step();
      wen = 0; exl_set = 0; exl_clr = 1; want("sr_after_clr", 0, 32'h0000_0400); step();
      exl_clr = 0;

      // Count wraps, then matches Compare=0
      wen = 1; sel = 5'd9; din = 32'hFFFF_FFFE; want("count_near_wrap", 0, 32'hFFFF_FFFE); step();
      sel = 5'd11; din = 32'h0; want("cmp_zero", 0, 32'h0); step();
      wen = 0; sel = 5'd9; want("count_wrap0", 0, 32'h0); want("wrap_no_irq", 2, 0); step();
      want("count_wrap1", 0, 32'h1); want("wrap_irq", 2, 1); step();

      // SR unused bits read 0
      wen = 1; sel = 5'd12; din = 32'hFFFF_FFFF; want("sr_mask", 0, 32'h0000_FC03); step();
      wen = 0;

      // Timer-less instance
      u1_wen = 1; u1_sel = 5'd9; u1_din = 32'd123; step();
      u1_wen = 0; want("u1_count_zero", 4, 32'h0); step();
      u1_sel = 5'd11; want("u1_cmp_zero", 4, 32'h0); step();
      u1_wen = 1; u1_sel = 5'd12; u1_din = 32'h0000_FC01; want("u1_im6", 4, 32'h0000_FC01); step();
      u1_wen = 0; u1_hwint = 6'b100000; want("u1_int_hw5", 5, 1); want("u1_no_timer", 6, 0); step();

      // Reset mid-operation discards a pending entry
      rst = 1; exl_set = 1; epc_in = 30'h55; sel = 5'd12;
      want("midrst_sr", 0, 32'h0); want("midrst_epc", 3, 32'h0); want("midrst_int", 1, 0); step();
      rst = 0; exl_set = 0; sel = 5'd11; want("midrst_cmp", 0, 32'hFFFF_FFFF); step();

      step();
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: got %0d pending expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cp0_timer_ctl.md
Name: cp0_timer_ctl

Overview:
- Parametrised system-control coprocessor for the pipelined MIPS core.
- Holds SR, Cause, EPC, PrID, and adds Count/Compare timer registers.
- Generalises hardware interrupt line count and makes the timer an optional internal interrupt source.
- Latches the exception code on entry; sits beside EX (mfc0/mtc0 traffic) and the bridge (external interrupt lines).

Parameters:
- NUM_HWINT, 5, number of external interrupt lines (1..6-TIMER_EN).
- TIMER_EN, 1, 1 = instantiate Count/Compare and the timer interrupt line.
- PRID_VAL, 32'hbbaaccff, read-only processor ID value.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- hwint  in  NUM_HWINT  external interrupt lines from bridge, level-sensitive.
- wen  in  1  mtc0 write strobe from EX.
- sel  in  5  CP0 register select: 9 Count, 11 Compare, 12 SR, 13 Cause, 14 EPC, 15 PrID.
- din  in  32  mtc0 write data.
- dout  out  32  mfc0 read data, combinational on sel.
- exl_set  in  1  exception/interrupt entry this cycle.
- exl_clr  in  1  eret this cycle.
- exc_code  in  5  cause code captured on exl_set (0 = interrupt).
- epc_in  in  30  return PC[31:2] captured on exl_set.
- epc_out  out  30  current EPC[31:2].
- int_req  out  1  interrupt request to pipeline.
- timer_irq  out  1  timer pending flag (0 when TIMER_EN=0).

Behaviour:
- Interrupt lines: L = NUM_HWINT+TIMER_EN lines, where L = {timer_irq if TIMER_EN, hwint}. Line i maps to SR/Cause bit 10+i, so the timer occupies the top line. Bits 10+L..15 read 0.
- SR layout:
  - SR = {16'b0, IM[15:10], 8'b0, EXL, IE}.
  - Unused IM bits are not writable and read 0.
- Cause layout:
  - Cause = {16'b0, IP[15:10], 3'b0, ExcCode[6:2], 2'b0}.
- Reset values: IM=0, IE=0, EXL=0, IP=0, ExcCode=0, EPC=0, Count=0, Compare=32'hFFFFFFFF, timer_irq=0. Consequently int_req=0 and dout follows sel.
- IP register:
  - Each cycle with EXL=0, IP <= L.
  - While EXL=1, IP holds, freezing the cause seen at entry.
  - 1-cycle latency from line to Cause readout.
- int_req:
  - Combinational: |(L & IM) & IE & ~EXL.
  - Uses live lines, not IP, so there is zero added latency.
- mtc0 (wen=1), effective next cycle:
  - sel 12 writes IM, EXL, IE.
  - sel 14 writes EPC <= din[31:2].
  - sel 9 writes Count.
  - sel 11 writes Compare and clears timer_irq.
  - sel 13 and 15 are ignored. Other sel values are ignored.
- Exception entry (exl_set=1):
  - EXL<=1, EPC<=epc_in, ExcCode<=exc_code.
  - Overrides a same-cycle mtc0 to SR.EXL or to EPC; other SR fields from that mtc0 still apply.
- eret (exl_clr=1):
  - EXL<=0.
  - If exl_set and exl_clr are both high, exl_set wins.
- Timer (TIMER_EN=1):
  - Count increments by 1 every cycle and wraps 32'hFFFFFFFF -> 0.
  - An mtc0 to Count loads din instead of incrementing that cycle.
  - When Count==Compare (pre-increment value), timer_irq <= 1 next cycle. It stays set until Compare is written.
  - A same-cycle match and Compare write: the write wins, so timer_irq=0.
- TIMER_EN=0: sel 9 and 11 read 0, writes are ignored, timer_irq is tied 0.
- dout: sel 9/11/12/13/14/15 return Count/Compare/SR/Cause/{EPC,2'b0}/PRID_VAL; any other sel returns 0.
- Reset mid-operation: all state returns to reset values on the next edge. A pending exl_set in that cycle is discarded.

Test Plan:
- Reset, then read sel 12/13/14/15 -> 0/0/0/32'hbbaaccff; int_req=0.
- Write SR=32'h0000_8401 (IM bit15 and bit10, IE), pulse hwint[0] -> int_req=1 same cycle; Cause[10]=1 next cycle; with hwint[1] only, int_req=0.
- exl_set with epc_in=30'h0000_1004, exc_code=0 while hwint[0]=1 -> EXL=1, epc_out=30'h1004, int_req=0; drop hwint[0], Cause[10] stays 1; exl_clr -> EXL=0, IP follows lines again.
- Write Compare=20, Count=10, IM bit15+IE -> timer_irq=1 and int_req=1 about 11 cycles later; write Compare=100 -> timer_irq=0.
- Same cycle: exl_set (epc_in=30'h40) and mtc0 EPC=32'h80 -> EPC=30'h40. Same cycle exl_set+exl_clr -> EXL=1.
- Count=32'hFFFFFFFE, Compare=0 -> wrap to 0 and timer_irq asserts one cycle after Count reads 0. Instance with TIMER_EN=0, NUM_HWINT=6 -> sel 9 reads 0, all six IM bits writable.
